mezclador_bandas: RTL and testbench
===================================

Name: mezclador_bandas

Overview:
- Recombines the three band outputs of the filter bank (bajos, medios, altos) into one equalized sample.
- Each band is multiplied by a run-time programmable gain, and the three products are summed.
- The multiplications run one after another on a single shared signed multiplier, under an FSM. The result is saturated back to the bank's fixed-point format.
- Sits directly downstream of the filter bank and shares its enable strobe and number format (sign/magnitud/fraccion).

Parameters:
- ancho, 23, total sample/gain width in bits (two's complement).
- signo, 1, sign bits in the fixed-point format.
- magnitud, 8, integer bits.
- fraccion, 14, fractional bits. 1.0 = 2^fraccion = 16384.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  sample strobe, same strobe that drives the filter bank; the bands are valid when en=1.
- ykbajos  in  ancho  signed low-band sample.
- ykmedios  in  ancho  signed mid-band sample.
- ykaltos  in  ancho  signed high-band sample.
- gain_we  in  1  gain write strobe.
- gain_sel  in  2  gain select: 0 bajos, 1 medios, 2 altos, 3 no write.
- gain_dato  in  ancho  signed gain value, same Q format as the samples.
- func_salida  out  ancho  signed equalized output sample, registered.
- valid  out  1  one-cycle pulse when func_salida updates.
- busy  out  1  high while the FSM is not IDLE.
- overrun  out  1  sticky flag: an en arrived while busy.

Behaviour:
- Reset (async, any time, including mid-sample):
  - state=IDLE; func_salida=0, valid=0, busy=0, overrun=0.
  - Active gains and shadow gains all = 2^fraccion (unity).
  - Accumulator and latched samples = 0.
- Gain write: on an edge with gain_we=1 and gain_sel<3, gain_dato is written into the shadow gain register for that band. gain_sel=3 does nothing.
- Gain transfer: shadow gains are copied into the active gains only when a sample is accepted, so a gain write never changes a sample already in progress.
- Gain write at the same edge as sample acceptance: the new value is used for that sample (write-through into the active copy).
- FSM states: IDLE -> MUL_B -> MUL_M -> MUL_A -> SAT -> IDLE.
- IDLE: if en=1, latch the three band inputs and the active gains, clear the accumulator, go to MUL_B. Otherwise stay.
- MUL_B: acc <= P(bajos, gain_b). MUL_M: acc <= acc + P(medios, gain_m). MUL_A: acc <= acc + P(altos, gain_a).
- SAT: func_salida <= SAT_ancho(acc); valid <= 1 for exactly one cycle; go to IDLE.
- Latency: en sampled high at edge k gives func_salida/valid at edge k+4.
  - valid is high during the cycle after edge k+4.
  - busy is high from after edge k until edge k+4.
  - Maximum throughput: one sample per 5 clocks.
- en while busy=1 (states MUL_B..SAT): the sample is dropped, overrun <= 1 and holds until reset. func_salida is unaffected.
- en in IDLE in the same cycle valid is high: accepted normally (back-to-back operation).
- Product P(x,g): full 2*ancho signed product, then arithmetic shift right by fraccion (floor, no rounding), then saturate to ancho bits.
- Saturation limits: max = 2^(ancho-1)-1 (4194303), min = -2^(ancho-1) (-4194304).
- Accumulator width is ancho+2, so a sum of three saturated products cannot wrap. Final SAT clamps to the same limits.
- func_salida holds its value between valid pulses.

Decomposition:
- Shared package holds:
  - The format constants (ancho, signo, magnitud, fraccion).
  - GAIN_UNITY = 1<<fraccion.
  - The SAT_MAX and SAT_MIN constants.
  - The state encoding (IDLE=0, MUL_B=1, MUL_M=2, MUL_A=3, SAT=4).
- One sub-module: mult_q_sat. Combinational signed multiply, shift by fraccion, and saturate to ancho. Reused by the FSM datapath; reusable by the filter bank.

Test Plan:
- Reset values: after reset, all gains unity. bajos=medios=altos=16384 (1.0) with en=1 for one cycle -> func_salida=49152 with valid pulsing 4 edges later; busy high for 4 cycles.
- Gain routing: write gain_sel=0 gain_dato=32768 (2.0). bajos=65536 (4.0), others 0 -> func_salida=131072. Same input with medios gain=-8192 (-0.5), medios=16384, bajos=0 -> -8192.
- Saturation: gains=4194303, bands=4194303 -> func_salida=4194303. Gains=4194303, bands=-4194304 -> -4194304.
- Overrun: en pulses at edges k and k+2 -> one valid pulse only, at k+4; overrun=1 and stays 1. en at k+5 -> accepted, valid at k+9.
- Gain mid-sample: gain write at edge k+2 of an in-progress sample does not change that result; it applies to the next sample.
- Reset mid-operation: assert reset during MUL_M -> busy=0, valid=0, func_salida=0 immediately (asynchronous). Next en is processed with unity gains.

Source files
------------

// File: rtl/mezclador_bandas_pkg.sv
// Shared fixed-point format, saturation limits and FSM encoding for the band mixer.
// Sized so the filter bank can import the same package.
package mezclador_bandas_pkg;

  localparam int signo    = 1;
  localparam int magnitud = 8;
  localparam int fraccion = 14;
  localparam int ancho    = signo + magnitud + fraccion;

  localparam int GAIN_UNITY = 1 << fraccion;
  localparam int SAT_MAX    = (1 << (ancho - 1)) - 1;
  localparam int SAT_MIN    = -(1 << (ancho - 1));

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL_B = 3'd1,
    MUL_M = 3'd2,
    MUL_A = 3'd3,
    SAT   = 3'd4
  } estado_t;

endpackage

// File: rtl/mult_q_sat.sv
// Combinational Q-format multiply: full-width signed product, floor shift by
// fraccion, then clamp to the ancho-bit two's complement range.
module mult_q_sat
  import mezclador_bandas_pkg::*;
(
  input  logic signed [ancho-1:0] x_i,
  input  logic signed [ancho-1:0] g_i,
  output logic signed [ancho-1:0] p_o
);

  localparam int PW = 2 * ancho;
  localparam logic signed [PW-1:0] P_MAX = PW'(SAT_MAX);
  localparam logic signed [PW-1:0] P_MIN = PW'(SAT_MIN);

  function automatic logic signed [ancho-1:0] sat_prod(input logic signed [PW-1:0] v);
    if (v > P_MAX)      return ancho'(SAT_MAX);
    else if (v < P_MIN) return ancho'(SAT_MIN);
    else                return v[ancho-1:0];
  endfunction

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_sh;

  always_comb begin
    prod    = PW'(x_i) * PW'(g_i);
    prod_sh = prod >>> fraccion;
    p_o     = sat_prod(prod_sh);
  end

endmodule

// File: rtl/mezclador_bandas.sv
// Three-band recombiner: one shared multiplier, sequenced by an FSM, applies
// per-band programmable gains and sums into a guarded accumulator.
module mezclador_bandas
  import mezclador_bandas_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic signed [ancho-1:0] ykbajos,
  input  logic signed [ancho-1:0] ykmedios,
  input  logic signed [ancho-1:0] ykaltos,
  input  logic                    gain_we,
  input  logic [1:0]              gain_sel,
  input  logic signed [ancho-1:0] gain_dato,
  output logic signed [ancho-1:0] func_salida,
  output logic                    valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int AW = ancho + 2;
  localparam logic signed [AW-1:0]    A_MAX = AW'(SAT_MAX);
  localparam logic signed [AW-1:0]    A_MIN = AW'(SAT_MIN);
  localparam logic signed [ancho-1:0] UNO   = ancho'(GAIN_UNITY);

  function automatic logic signed [ancho-1:0] sat_acc(input logic signed [AW-1:0] v);
    if (v > A_MAX)      return ancho'(SAT_MAX);
    else if (v < A_MIN) return ancho'(SAT_MIN);
    else                return v[ancho-1:0];
  endfunction

  estado_t                 estado_q;
  logic signed [ancho-1:0] gsh_q  [3];
  logic signed [ancho-1:0] gsh_d  [3];
  logic signed [ancho-1:0] gact_q [3];
  logic signed [ancho-1:0] x_q    [3];
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [ancho-1:0] func_q;
  logic                    valid_q, overrun_q;
  logic signed [ancho-1:0] mul_x, mul_g, mul_p;

  // Shadow next-state doubles as the write-through path into the active gains.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      gsh_d[i] = (gain_we && (gain_sel == 2'(i))) ? gain_dato : gsh_q[i];
    end
  end

  always_comb begin
    mul_x = '0;
    mul_g = '0;
    case (estado_q)
      MUL_B: begin mul_x = x_q[0]; mul_g = gact_q[0]; end
      MUL_M: begin mul_x = x_q[1]; mul_g = gact_q[1]; end
      MUL_A: begin mul_x = x_q[2]; mul_g = gact_q[2]; end
      default: ;
    endcase
  end

  mult_q_sat u_mult (
    .x_i (mul_x),
    .g_i (mul_g),
    .p_o (mul_p)
  );

  always_comb begin
    acc_d = acc_q;
    case (estado_q)
      MUL_B:        acc_d = AW'(mul_p);
      MUL_M, MUL_A: acc_d = acc_q + AW'(mul_p);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= IDLE;
      acc_q     <= '0;
      func_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        gsh_q[i]  <= UNO;
        gact_q[i] <= UNO;
        x_q[i]    <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) gsh_q[i] <= gsh_d[i];
      if (en && (estado_q != IDLE)) overrun_q <= 1'b1;
      case (estado_q)
        IDLE: begin
          if (en) begin
            x_q[0] <= ykbajos;
            x_q[1] <= ykmedios;
            x_q[2] <= ykaltos;
            for (int i = 0; i < 3; i++) gact_q[i] <= gsh_d[i];
            acc_q    <= '0;
            estado_q <= MUL_B;
          end
        end
        MUL_B: begin acc_q <= acc_d; estado_q <= MUL_M; end
        MUL_M: begin acc_q <= acc_d; estado_q <= MUL_A; end
        MUL_A: begin acc_q <= acc_d; estado_q <= SAT;   end
        SAT: begin
          func_q   <= sat_acc(acc_q);
          valid_q  <= 1'b1;
          estado_q <= IDLE;
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign func_salida = func_q;
  assign valid       = valid_q;
  assign busy        = (estado_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_mezclador_bandas.sv
// Directed bench for the band mixer: reset, gain routing, saturation,
// write-through, mid-sample gain writes, overrun and asynchronous reset.
module tb_mezclador_bandas;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic signed [22:0] ykbajos, ykmedios, ykaltos;
  logic               gain_we;
  logic [1:0]         gain_sel;
  logic signed [22:0] gain_dato;
  logic signed [22:0] func_salida;
  logic               valid, busy, overrun;

  int n_cmp = 0;
  int n_err = 0;

  mezclador_bandas dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .ykbajos     (ykbajos),
    .ykmedios    (ykmedios),
    .ykaltos     (ykaltos),
    .gain_we     (gain_we),
    .gain_sel    (gain_sel),
    .gain_dato   (gain_dato),
    .func_salida (func_salida),
    .valid       (valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int b, input int m, input int a);
    ykbajos  = 23'(b);
    ykmedios = 23'(m);
    ykaltos  = 23'(a);
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic write_gain(input int sel, input int val);
    gain_we   = 1'b1;
    gain_sel  = 2'(sel);
    gain_dato = 23'(val);
    tick();
    gain_we  = 1'b0;
    gain_sel = 2'd3;
  endtask

  task automatic test_reset();
    n_cmp++; if (func_salida !== 23'sd0) begin n_err++; $display("FAIL rst_func got=%0d exp=0", func_salida); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b exp=0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun got=%0b exp=0", overrun); end
    reset = 1'b0;
    launch(16384, 16384, 16384);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (busy !== 1'b1 || valid !== 1'b0) begin
        n_err++; $display("FAIL unity_busy_k%0d got busy=%0b valid=%0b exp busy=1 valid=0", i, busy, valid);
      end
      tick();
    end
    n_cmp++; if (valid !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL unity_valid got valid=%0b busy=%0b exp valid=1 busy=0", valid, busy);
    end
    n_cmp++; if (func_salida !== 23'sd49152) begin n_err++; $display("FAIL unity_sum got=%0d exp=49152", func_salida); end
    tick();
    n_cmp++; if (valid !== 1'b0 || func_salida !== 23'sd49152) begin
      n_err++; $display("FAIL unity_hold got valid=%0b func=%0d exp valid=0 func=49152", valid, func_salida);
    end
  endtask

  task automatic test_gain_routing();
    write_gain(0, 32768);
    launch(65536, 0, 0);
    repeat (4) tick();
    n_cmp++; if (valid !== 1'b1 || func_salida !== 23'sd131072) begin
      n_err++; $display("FAIL gain_bajos got valid=%0b func=%0d exp valid=1 func=131072", valid, func_salida);
    end
    write_gain(1, -8192);
    launch(0, 16384, 0);
    repeat (4) tick();
    n_cmp++; if (valid !== 1'b1 || func_salida !== -23'sd8192) begin
      n_err++; $display("FAIL gain_medios got valid=%0b func=%0d exp valid=1 func=-8192", valid, func_salida);
    end
    tick();
  endtask

  task automatic test_saturation();
    for (int s = 0; s < 3; s++) write_gain(s, 4194303);
    launch(4194303, 4194303, 4194303);
    repeat (4) tick();
    n_cmp++; if (func_salida !== 23'sd4194303) begin n_err++; $display("FAIL sat_pos got=%0d exp=4194303", func_salida); end
    launch(-4194304, -4194304, -4194304);
    repeat (4) tick();
    n_cmp++; if (func_salida !== -23'sd4194304) begin n_err++; $display("FAIL sat_neg got=%0d exp=-4194304", func_salida); end
    tick();
  endtask

  task automatic test_write_through();
    gain_we   = 1'b1;
    gain_sel  = 2'd2;
    gain_dato = 23'sd8192;
    launch(0, 0, 16384);
    gain_we  = 1'b0;
    gain_sel = 2'd3;
    repeat (4) tick();
    n_cmp++; if (func_salida !== 23'sd8192) begin n_err++; $display("FAIL write_through got=%0d exp=8192", func_salida); end
    write_gain(3, 0);
    launch(0, 0, 16384);
    repeat (4) tick();
    n_cmp++; if (func_salida !== 23'sd8192) begin n_err++; $display("FAIL sel3_nowrite got=%0d exp=8192", func_salida); end
    tick();
  endtask

  task automatic test_gain_mid_sample();
    launch(0, 0, 16384);
    tick();
    write_gain(2, 32768);
    repeat (2) tick();
    n_cmp++; if (valid !== 1'b1 || func_salida !== 23'sd8192) begin
      n_err++; $display("FAIL mid_gain_old got valid=%0b func=%0d exp valid=1 func=8192", valid, func_salida);
    end
    launch(0, 0, 16384);
    repeat (4) tick();
    n_cmp++; if (func_salida !== 23'sd32768) begin n_err++; $display("FAIL mid_gain_next got=%0d exp=32768", func_salida); end
    tick();
  endtask

  task automatic test_overrun();
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_initial got=%0b exp=0", overrun); end
    launch(0, 0, 16384);
    tick();
    launch(0, 0, 1000);
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%0b exp=1", overrun); end
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_early_valid got=%0b exp=0", valid); end
    tick();
    n_cmp++; if (valid !== 1'b1 || func_salida !== 23'sd32768) begin
      n_err++; $display("FAIL ovr_result got valid=%0b func=%0d exp valid=1 func=32768", valid, func_salida);
    end
    launch(0, 0, 4096);
    n_cmp++; if (valid !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL b2b_accept got valid=%0b busy=%0b exp valid=0 busy=1", valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_no_valid_%0d got=%0b exp=0", i, valid); end
    end
    tick();
    n_cmp++; if (valid !== 1'b1 || func_salida !== 23'sd8192) begin
      n_err++; $display("FAIL b2b_result got valid=%0b func=%0d exp valid=1 func=8192", valid, func_salida);
    end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky got=%0b exp=1", overrun); end
    tick();
  endtask

  task automatic test_reset_mid();
    launch(16384, 16384, 16384);
    tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || valid !== 1'b0) begin
      n_err++; $display("FAIL amid_ctrl got busy=%0b valid=%0b exp busy=0 valid=0", busy, valid);
    end
    n_cmp++; if (func_salida !== 23'sd0 || overrun !== 1'b0) begin
      n_err++; $display("FAIL amid_data got func=%0d overrun=%0b exp func=0 overrun=0", func_salida, overrun);
    end
    #1 reset = 1'b0;
    launch(16384, 16384, 16384);
    repeat (4) tick();
    n_cmp++; if (valid !== 1'b1 || func_salida !== 23'sd49152) begin
      n_err++; $display("FAIL amid_unity got valid=%0b func=%0d exp valid=1 func=49152", valid, func_salida);
    end
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    ykbajos   = '0;
    ykmedios  = '0;
    ykaltos   = '0;
    gain_we   = 1'b0;
    gain_sel  = 2'd3;
    gain_dato = '0;
    repeat (2) tick();
    test_reset();
    test_gain_routing();
    test_saturation();
    test_write_through();
    test_gain_mid_sample();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
